// File: rtl/rtc_pkg.sv
// Shared types and constants for the DS3231 time reader.
package rtc_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] RTC_ADDR_DEFAULT = 7'h68;

    localparam int unsigned REG_SEC  = 0;
    localparam int unsigned REG_MIN  = 1;
    localparam int unsigned REG_HOUR = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_START,
        ST_SET_BYTE,
        ST_PTR_START,
        ST_PTR_BYTE,
        ST_PTR_END,
        ST_GAP1,
        ST_RD_START,
        ST_RD_COLLECT,
        ST_GAP2,
        ST_UPDATE,
        ST_ERR_GAP
    } state_t;

    // States covered by the transaction timeout (start pulse up to GAP2 entry)
    function automatic logic in_txn(input state_t s);
        return (s != ST_IDLE) && (s != ST_GAP2) && (s != ST_UPDATE) && (s != ST_ERR_GAP);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Generic registered rising-edge detector; rise_c is combinational.
module rise_detect (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) d_q <= 1'b0;
        else          d_q <= d;
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/rtc_time_reader.sv
// Polls DS3231 seconds/minutes/hours through the I2C master core handshake.
// Define RTC_SET_EN to add the time-set write path (set_* ports).
module rtc_time_reader
    import rtc_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 2_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter logic [6:0]  RTC_ADDR       = RTC_ADDR_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    output logic       wr_address,
    output logic       rd_address,
    output logic [6:0] data_address,
    output logic [7:0] byte_read,
    output logic       in_valid,
    output logic [7:0] in_data,
    input  logic       in_ready,
    input  logic       out_valid,
    input  logic [7:0] out_data,
`ifdef RTC_SET_EN
    input  logic       set_req,
    input  logic [6:0] set_sec,
    input  logic [6:0] set_min,
    input  logic [5:0] set_hour,
`endif
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [5:0] hour,
    output logic       time_valid,
    output logic       err
);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [CNT_W-1:0]       tmo, tmo_n;
    logic [1:0]             idx, idx_n;
    logic [3:0][7:0]        rd_buf, rd_buf_n;
    logic                   wr_address_n, rd_address_n, in_valid_n, time_valid_n, err_n;
    logic [7:0]             in_data_n;
    logic [6:0]             sec_n, min_n;
    logic [5:0]             hour_n;
    logic                   ready_rise_c;
    logic                   unused_bits;

`ifdef RTC_SET_EN
    logic                   pend, pend_n;
    logic [6:0]             pend_sec, pend_sec_n, pend_min, pend_min_n;
    logic [5:0]             pend_hour, pend_hour_n;
`endif

    assign data_address = RTC_ADDR;
    assign byte_read    = 8'd3;
    assign unused_bits  = ^{rd_buf[3], rd_buf[0][7], rd_buf[1][7], rd_buf[2][7:6]};

    rise_detect u_ready_rise (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .d       (in_ready),
        .rise_c  (ready_rise_c)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tmo        <= '0;
            idx        <= '0;
            rd_buf     <= '0;
            wr_address <= 1'b0;
            rd_address <= 1'b0;
            in_valid   <= 1'b0;
            in_data    <= '0;
            sec        <= '0;
            min        <= '0;
            hour       <= '0;
            time_valid <= 1'b0;
            err        <= 1'b0;
`ifdef RTC_SET_EN
            pend       <= 1'b0;
            pend_sec   <= '0;
            pend_min   <= '0;
            pend_hour  <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tmo        <= tmo_n;
            idx        <= idx_n;
            rd_buf     <= rd_buf_n;
            wr_address <= wr_address_n;
            rd_address <= rd_address_n;
            in_valid   <= in_valid_n;
            in_data    <= in_data_n;
            sec        <= sec_n;
            min        <= min_n;
            hour       <= hour_n;
            time_valid <= time_valid_n;
            err        <= err_n;
`ifdef RTC_SET_EN
            pend       <= pend_n;
            pend_sec   <= pend_sec_n;
            pend_min   <= pend_min_n;
            pend_hour  <= pend_hour_n;
`endif
        end
    end

    // Outputs are computed one cycle ahead so every strobe leaves a flop
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        rd_buf_n     = rd_buf;
        wr_address_n = 1'b0;
        rd_address_n = 1'b0;
        in_valid_n   = 1'b0;
        in_data_n    = 8'h00;
        sec_n        = sec;
        min_n        = min;
        hour_n       = hour;
        time_valid_n = 1'b0;
        err_n        = err;
`ifdef RTC_SET_EN
        pend_n       = pend;
        pend_sec_n   = pend_sec;
        pend_min_n   = pend_min;
        pend_hour_n  = pend_hour;
`endif

        unique case (state)
            ST_IDLE: begin
`ifdef RTC_SET_EN
                if (pend) begin
                    state_n      = ST_SET_START;
                    wr_address_n = 1'b1;
                    pend_n       = 1'b0;
                end else
`endif
                if (cnt == CNT_W'(POLL_CYCLES - 1)) begin
                    state_n      = ST_PTR_START;
                    wr_address_n = 1'b1;
                end
            end
            ST_SET_START: begin
                idx_n   = 2'd0;
                state_n = ST_SET_BYTE;
            end
            ST_SET_BYTE: begin
`ifdef RTC_SET_EN
                if (ready_rise_c) begin
                    in_valid_n = 1'b1;
                    unique case (idx)
                        2'd0:    in_data_n = 8'h00;
                        2'd1:    in_data_n = {1'b0, pend_sec};
                        2'd2:    in_data_n = {1'b0, pend_min};
                        default: in_data_n = {2'b00, pend_hour};
                    endcase
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = ST_PTR_END;
                end
`else
                state_n = ST_IDLE;
`endif
            end
            ST_PTR_START: state_n = ST_PTR_BYTE;
            ST_PTR_BYTE: begin
                if (ready_rise_c) begin
                    in_valid_n = 1'b1;
                    in_data_n  = 8'h00;
                    state_n    = ST_PTR_END;
                end
            end
            // Withholding the strobe here makes the core NACK and send STOP
            ST_PTR_END: if (ready_rise_c) state_n = ST_GAP1;
            ST_GAP1: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_n      = ST_RD_START;
                    rd_address_n = 1'b1;
                end
            end
            ST_RD_START: begin
                idx_n   = 2'd0;
                state_n = ST_RD_COLLECT;
            end
            ST_RD_COLLECT: begin
                if (out_valid) begin
                    rd_buf_n[idx] = out_data;
                    idx_n         = idx + 2'd1;
                    if (idx == 2'd2) state_n = ST_GAP2;
                end
            end
            ST_GAP2: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_n      = ST_UPDATE;
                    time_valid_n = 1'b1;
                    sec_n        = rd_buf[REG_SEC][6:0];
                    min_n        = rd_buf[REG_MIN][6:0];
                    hour_n       = rd_buf[REG_HOUR][5:0];
                    err_n        = 1'b0;
                end
            end
            ST_UPDATE: state_n = ST_IDLE;
            ST_ERR_GAP: if (cnt == CNT_W'(GAP_CYCLES - 1)) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Abort overrides whatever the transaction state wanted this cycle
        if (in_txn(state) && (tmo == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state_n      = ST_ERR_GAP;
            err_n        = 1'b1;
            wr_address_n = 1'b0;
            rd_address_n = 1'b0;
            in_valid_n   = 1'b0;
            in_data_n    = 8'h00;
        end

`ifdef RTC_SET_EN
        if (set_req) begin
            pend_n      = 1'b1;
            pend_sec_n  = set_sec;
            pend_min_n  = set_min;
            pend_hour_n = set_hour;
        end
`endif

        cnt_n = (state_n != state) ? '0 : cnt + CNT_W'(1);
        tmo_n = in_txn(state) ? tmo + CNT_W'(1) : '0;
    end

endmodule
